// File: rtl/counter_gray_receiver_if.sv
// Bus bundle for counter_gray_receiver: Gray count in, decoded count/delta out, consumer handshake.
// The master side drives gray_in, delta_ack and error_clear; the slave side is the receiver.
interface counter_gray_receiver_if #(
    parameter int W = 8
);
    logic [W-1:0] gray_in;
    logic [W-1:0] count;
    logic [W-1:0] delta;
    logic         delta_valid;
    logic         delta_ack;
    logic         error;
    logic         error_clear;

    modport master (
        output gray_in, delta_ack, error_clear,
        input  count, delta, delta_valid, error
    );

    modport slave (
        input  gray_in, delta_ack, error_clear,
        output count, delta, delta_valid, error
    );
endinterface

// File: rtl/counter_gray_receiver.sv
// Synchronises a foreign-domain Gray count, decodes it, accumulates increments for a consumer and flags illegal transitions.
// Optional macro COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN: a changed sample must hold for 2 cycles before it is accepted.
module counter_gray_receiver #(
    parameter int MAX_VALUE   = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    counter_gray_receiver_if.slave bus
);
    localparam int W  = $clog2(MAX_VALUE + 1);
    localparam int CW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_sync [SYNC_STAGES];
    logic [CW-1:0]  r_initCnt;
    logic [W-1:0]   r_prev;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_delta;
    logic           r_deltaValid;
    logic           r_error;
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
    logic [W-1:0]   r_cand;
    logic           r_candValid;
`endif

    logic [W-1:0]   w_sample;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_newBin;
    logic           w_changed;
    logic           w_accept;
    logic           w_illegal;
    logic [W:0]     w_stepRaw;
    logic [W:0]     w_step;
    logic [W-1:0]   w_base;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_nextDelta;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_sample = r_sync[SYNC_STAGES-1];

    // Old value is always the current count, so the wrap step needs no second decode.
    always_comb begin
        w_diff    = w_sample ^ r_prev;
        w_newBin  = gray2bin(w_sample);
        w_changed = (r_state == TRACK) && (w_sample != r_prev);
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
        w_accept  = w_changed && r_candValid && (w_sample == r_cand);
`else
        w_accept  = w_changed;
`endif
        w_illegal = ((w_diff & (w_diff - W'(1))) != '0) ||
                    ({1'b0, w_newBin} > (W+1)'(MAX_VALUE));
        if (w_newBin >= r_count) begin
            w_stepRaw = {1'b0, w_newBin} - {1'b0, r_count};
        end else begin
            w_stepRaw = {1'b0, w_newBin} + (W+1)'(MAX_VALUE + 1) - {1'b0, r_count};
        end
        w_step      = (w_accept && !w_illegal) ? w_stepRaw : '0;
        w_base      = (bus.delta_ack && r_deltaValid) ? '0 : r_delta;
        w_sum       = {1'b0, w_base} + w_step;
        w_nextDelta = (w_sum > (W+1)'(MAX_VALUE)) ? W'(MAX_VALUE) : w_sum[W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_state      <= INIT;
            r_initCnt    <= '0;
            r_prev       <= '0;
            r_count      <= '0;
            r_delta      <= '0;
            r_deltaValid <= 1'b0;
            r_error      <= 1'b0;
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
            r_cand       <= '0;
            r_candValid  <= 1'b0;
`endif
        end else begin
            r_sync[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_delta      <= w_nextDelta;
            r_deltaValid <= (w_nextDelta != '0);
            if (w_accept && w_illegal) begin
                r_error <= 1'b1;
            end else if (bus.error_clear) begin
                r_error <= 1'b0;
            end
            case (r_state)
                INIT: begin
                    if (r_initCnt == CW'(SYNC_STAGES)) begin
                        r_prev  <= w_sample;
                        r_count <= w_newBin;
                        r_state <= TRACK;
                    end else begin
                        r_initCnt <= r_initCnt + CW'(1);
                    end
                end
                TRACK: begin
                    if (w_accept) begin
                        r_prev  <= w_sample;
                        r_count <= w_newBin;
                    end
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
                    // A sample that reverts before confirmation just clears the candidate.
                    if (w_changed && !w_accept) begin
                        r_cand      <= w_sample;
                        r_candValid <= 1'b1;
                    end else begin
                        r_candValid <= 1'b0;
                    end
`endif
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.count       = r_count;
    assign bus.delta       = r_delta;
    assign bus.delta_valid = r_deltaValid;
    assign bus.error       = r_error;
endmodule

// File: tb/tb_counter_gray_receiver.sv
// Self-checking bench for counter_gray_receiver: directed scenarios plus a randomized walk against a count/delta model.
module tb_counter_gray_receiver;
    localparam int MAXV = 255;
    localparam int SYNC = 2;
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 2;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    int   mCount;
    int   mDelta;
    int   mGray;
    bit   mErr;

    counter_gray_receiver_if #(.W(8)) bus ();

    counter_gray_receiver #(
        .MAX_VALUE   (MAXV),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toGray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Reference: a new accepted value updates count; legal moves add the modular distance to delta.
    function automatic void modelMove(input int v);
        int g;
        int old;
        int step;
        bit ill;
        g = toGray(v);
        if (g == mGray) return;
        old    = mCount;
        mCount = v;
        ill    = ($countones(g ^ mGray) > 1) || (v > MAXV);
        mGray  = g;
        if (ill) begin
            mErr = 1'b1;
        end else begin
            step   = (v >= old) ? v - old : v + MAXV + 1 - old;
            mDelta = (mDelta + step > MAXV) ? MAXV : mDelta + step;
        end
    endfunction

    task automatic resetTo(input int v);
        @(negedge clk);
        reset           = 1'b0;
        bus.gray_in     = 8'(toGray(v));
        bus.delta_ack   = 1'b0;
        bus.error_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        mCount = v;
        mDelta = 0;
        mGray  = toGray(v);
        mErr   = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int v);
        bus.gray_in = 8'(toGray(v));
        modelMove(v);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.gray_in = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (bus.count !== 8'd0 || bus.delta !== 8'd0 || bus.delta_valid !== 1'b0 || bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_hold: count=%0d delta=%0d valid=%0b err=%0b, want all 0",
                     bus.count, bus.delta, bus.delta_valid, bus.error);
        end
        bus.gray_in = 8'd0;
        reset       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            nChecks++;
            if (bus.count !== 8'd0 || bus.delta_valid !== 1'b0 || bus.error !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL reset_idle[%0d]: count=%0d valid=%0b err=%0b, want 0 0 0",
                         i, bus.count, bus.delta_valid, bus.error);
            end
        end
    endtask

    task automatic test_baseline();
        resetTo(37);
        nChecks++;
        if (bus.count !== 8'd37 || bus.delta !== 8'd0 || bus.delta_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL baseline_capture: count=%0d delta=%0d valid=%0b, want 37 0 0",
                     bus.count, bus.delta, bus.delta_valid);
        end
        applyStimulus(38);
        applyStimulus(39);
        nChecks++;
        if (bus.count !== 8'd39 || bus.delta !== 8'd2 || bus.delta_valid !== 1'b1 || bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL baseline_steps: count=%0d delta=%0d valid=%0b err=%0b, want 39 2 1 0",
                     bus.count, bus.delta, bus.delta_valid, bus.error);
        end
    endtask

    task automatic test_wrap();
        resetTo(254);
        applyStimulus(255);
        applyStimulus(0);
        nChecks++;
        if (bus.count !== 8'd0 || bus.delta !== 8'd2 || bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL wrap: count=%0d delta=%0d err=%0b, want 0 2 0", bus.count, bus.delta, bus.error);
        end
    endtask

    task automatic test_saturation();
        resetTo(0);
        applyStimulus(255);
        nChecks++;
        if (bus.delta !== 8'(mDelta) || mDelta != 255) begin
            nFails++;
            $display("[TB] FAIL sat_full: delta=%0d, want 255", bus.delta);
        end
        applyStimulus(0);
        nChecks++;
        if (bus.delta !== 8'd255 || bus.count !== 8'd0 || bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL sat_clamp: delta=%0d count=%0d err=%0b, want 255 0 0", bus.delta, bus.count, bus.error);
        end
    endtask

    task automatic test_back_to_back();
        resetTo(10);
        applyStimulus(11);
        applyStimulus(12);
        applyStimulus(13);
        nChecks++;
        if (bus.delta !== 8'd3) begin
            nFails++;
            $display("[TB] FAIL collide_pre: delta=%0d, want 3", bus.delta);
        end
        bus.gray_in = 8'(toGray(14));
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (bus.count !== 8'd13) begin
            nFails++;
            $display("[TB] FAIL latency_early: count=%0d, want 13", bus.count);
        end
        bus.delta_ack = 1'b1;
        mDelta = 0;
        modelMove(14);
        @(posedge clk);
        @(negedge clk);
        bus.delta_ack = 1'b0;
        nChecks++;
        if (bus.delta !== 8'd1 || bus.delta_valid !== 1'b1 || bus.count !== 8'd14) begin
            nFails++;
            $display("[TB] FAIL collide_ack: delta=%0d valid=%0b count=%0d, want 1 1 14",
                     bus.delta, bus.delta_valid, bus.count);
        end
        bus.delta_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.delta_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (bus.delta !== 8'd0 || bus.delta_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ack_drain: delta=%0d valid=%0b, want 0 0", bus.delta, bus.delta_valid);
        end
    endtask

    task automatic test_illegal();
        resetTo(4);
        applyStimulus(5);
        applyStimulus(7);
        nChecks++;
        if (bus.error !== 1'b1 || bus.count !== 8'd7 || bus.delta !== 8'd1) begin
            nFails++;
            $display("[TB] FAIL illegal_jump: err=%0b count=%0d delta=%0d, want 1 7 1", bus.error, bus.count, bus.delta);
        end
        bus.gray_in = 8'(toGray(2));
        modelMove(2);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        bus.error_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.error_clear = 1'b0;
        nChecks++;
        if (bus.error !== 1'b1 || bus.count !== 8'd2 || bus.delta !== 8'd1) begin
            nFails++;
            $display("[TB] FAIL set_wins: err=%0b count=%0d delta=%0d, want 1 2 1", bus.error, bus.count, bus.delta);
        end
        bus.error_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.error_clear = 1'b0;
        nChecks++;
        if (bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL error_clear: err=%0b, want 0", bus.error);
        end
    endtask

`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
    task automatic test_glitch();
        resetTo(5);
        bus.gray_in = 8'(toGray(6));
        @(posedge clk);
        @(negedge clk);
        bus.gray_in = 8'(toGray(5));
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (bus.count !== 8'd5 || bus.delta !== 8'd0 || bus.error !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL glitch_drop: count=%0d delta=%0d err=%0b, want 5 0 0", bus.count, bus.delta, bus.error);
        end
    endtask
`endif

    task automatic test_random();
        int v;
        int r;
        resetTo(100);
        v = 100;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       v = (v + 1) % (MAXV + 1);
            else if (r < 7)  v = (v + MAXV) % (MAXV + 1);
            else if (r == 7) v = $urandom_range(0, MAXV);
            applyStimulus(v);
            if ($urandom_range(0, 2) == 0) begin
                bus.delta_ack = 1'b1;
                if (mDelta != 0) mDelta = 0;
                @(posedge clk);
                @(negedge clk);
                bus.delta_ack = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.error_clear = 1'b1;
                mErr = 1'b0;
                @(posedge clk);
                @(negedge clk);
                bus.error_clear = 1'b0;
            end
            nChecks++;
            if (bus.count !== 8'(mCount) || bus.delta !== 8'(mDelta) ||
                bus.delta_valid !== (mDelta != 0) || bus.error !== mErr) begin
                nFails++;
                $display("[TB] FAIL random[%0d]: count=%0d delta=%0d valid=%0b err=%0b, want %0d %0d %0b %0b",
                         i, bus.count, bus.delta, bus.delta_valid, bus.error, mCount, mDelta, (mDelta != 0), mErr);
            end
        end
    endtask

    initial begin
        nChecks         = 0;
        nFails          = 0;
        reset           = 1'b0;
        bus.gray_in     = '0;
        bus.delta_ack   = 1'b0;
        bus.error_clear = 1'b0;
        test_reset();
        test_baseline();
        test_wrap();
        test_saturation();
        test_back_to_back();
        test_illegal();
`ifdef COUNTER_GRAY_RECEIVER_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
